// File: rtl/axis_pattern_gen_mm_if.sv
// AXI-Stream master bundle for the pattern generator: data, valid, last and sink ready.
interface axis_pattern_gen_mm_if #(
  parameter int unsigned TDATA_WIDTH = 32
) ();
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_pattern_gen_mm.sv
// Multi-mode AXI-Stream test pattern source: rate-divided ticks feed a bounded virtual backlog,
// words are emitted gaplessly in counter / PRBS-32 / walking-one / alternating mode, grouped
// into fixed-length frames with TLAST. Mode changes only take effect at frame boundaries.
module axis_pattern_gen_mm #(
  parameter int unsigned TDATA_WIDTH   = 32,
  parameter int unsigned COUNTER_START = 0,
  parameter int unsigned COUNTER_END   = 255,
  parameter int unsigned COUNTER_INCR  = 1,
  parameter int unsigned DIVIDER       = 8,
  parameter int unsigned FRAME_LEN     = 64,
  parameter int unsigned BACKLOG_DEPTH = 16,
  parameter logic [31:0] LFSR_SEED     = 32'h0000_0001
) (
  input  logic                                 m_axis_aclk,
  input  logic                                 m_axis_areset,
  input  logic                                 enable,
  input  logic [1:0]                           mode,
  axis_pattern_gen_mm_if.master                m_axis,
  output logic [$clog2(BACKLOG_DEPTH+1)-1:0]   backlog,
  output logic [31:0]                          overflow_count
);

  localparam int unsigned DivW  = $clog2(DIVIDER);
  localparam int unsigned BlW   = $clog2(BACKLOG_DEPTH + 1);
  localparam int unsigned BeatW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [DivW-1:0]        DivReload  = DivW'(DIVIDER - 1);
  localparam logic [BlW-1:0]         BlFull     = BlW'(BACKLOG_DEPTH);
  localparam logic [BeatW-1:0]       BeatLast   = BeatW'(FRAME_LEN - 1);
  localparam logic [TDATA_WIDTH-1:0] CntStart   = TDATA_WIDTH'(COUNTER_START);
  localparam logic [TDATA_WIDTH-1:0] CntIncr    = TDATA_WIDTH'(COUNTER_INCR);
  // Values at or above this threshold wrap back towards COUNTER_START.
  localparam logic [TDATA_WIDTH-1:0] CntWrapAt  = TDATA_WIDTH'(COUNTER_END - COUNTER_INCR + 1);
  // cur + INCR - (END - START) - 1 rewritten as a single non-negative subtraction.
  localparam logic [TDATA_WIDTH-1:0] CntWrapSub =
      TDATA_WIDTH'(COUNTER_END - COUNTER_START + 1 - COUNTER_INCR);
  localparam logic [2*TDATA_WIDTH-1:0] AltRep   = {TDATA_WIDTH{2'b10}};
  localparam logic [TDATA_WIDTH-1:0]   AltSeed  = AltRep[TDATA_WIDTH-1:0];
  localparam logic [TDATA_WIDTH-1:0]   WalkSeed = TDATA_WIDTH'(1);

  typedef enum logic [1:0] {
    ModeCount = 2'd0,
    ModePrbs  = 2'd1,
    ModeWalk  = 2'd2,
    ModeAlt   = 2'd3
  } mode_e;

  logic [DivW-1:0]        divctr_q, divctr_d;
  logic [BlW-1:0]         backlog_q, backlog_d;
  logic [31:0]            ovf_q, ovf_d;
  logic [BeatW-1:0]       beat_q, beat_d;
  mode_e                  mode_q, mode_d;
  logic [TDATA_WIDTH-1:0] data_q, data_d;
  logic [31:0]            lfsr_q, lfsr_d;

  logic  tick, tick_acc, valid, hs, last_beat, latch_mode, reload;
  mode_e mode_req;

  assign mode_req   = mode_e'(mode);
  assign valid      = (backlog_q != '0);
  assign hs         = valid & m_axis.tready;
  assign tick       = (divctr_q == '0) & enable;
  // A full backlog still accepts a tick when a beat leaves in the same cycle.
  assign tick_acc   = tick & ((backlog_q < BlFull) | hs);
  assign last_beat  = (beat_q == BeatLast);
  assign latch_mode = (hs & last_beat) | (~valid & (beat_q == '0));
  assign reload     = latch_mode & (mode_req != mode_q);

  // Next-state for divider, backlog, overflow counter and frame position.
  always_comb begin
    divctr_d  = (divctr_q == '0) ? DivReload : divctr_q - DivW'(1);
    backlog_d = backlog_q;
    ovf_d     = ovf_q;
    beat_d    = beat_q;
    mode_d    = latch_mode ? mode_req : mode_q;
    if (tick_acc && !hs) begin
      backlog_d = backlog_q + BlW'(1);
    end else if (!tick_acc && hs) begin
      backlog_d = backlog_q - BlW'(1);
    end
    if (tick && !tick_acc && (ovf_q != '1)) begin
      ovf_d = ovf_q + 32'd1;
    end
    if (hs) begin
      beat_d = last_beat ? '0 : beat_q + BeatW'(1);
    end
  end

  // Pattern advance on handshake, or seed reload when the latched mode changes.
  always_comb begin
    data_d = data_q;
    lfsr_d = lfsr_q;
    if (reload) begin
      lfsr_d = LFSR_SEED;
      case (mode_req)
        ModeWalk: data_d = WalkSeed;
        ModeAlt:  data_d = AltSeed;
        default:  data_d = CntStart;
      endcase
    end else if (hs) begin
      case (mode_q)
        ModeCount: data_d = (data_q >= CntWrapAt) ? data_q - CntWrapSub : data_q + CntIncr;
        ModePrbs:  lfsr_d = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
        ModeWalk:  data_d = {data_q[TDATA_WIDTH-2:0], data_q[TDATA_WIDTH-1]};
        default:   data_d = ~data_q;
      endcase
    end
  end

  // State registers; everything clears asynchronously on reset.
  always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
    if (m_axis_areset) begin
      divctr_q  <= DivReload;
      backlog_q <= '0;
      ovf_q     <= '0;
      beat_q    <= '0;
      mode_q    <= ModeCount;
      data_q    <= CntStart;
      lfsr_q    <= LFSR_SEED;
    end else begin
      divctr_q  <= divctr_d;
      backlog_q <= backlog_d;
      ovf_q     <= ovf_d;
      beat_q    <= beat_d;
      mode_q    <= mode_d;
      data_q    <= data_d;
      lfsr_q    <= lfsr_d;
    end
  end

  // Output word selection; PRBS words are the low LFSR bits, zero-extended on wide buses.
  always_comb begin
    m_axis.tdata = data_q;
    if (mode_q == ModePrbs) begin
      m_axis.tdata = TDATA_WIDTH'(lfsr_q);
    end
  end

  assign m_axis.tvalid  = valid;
  assign m_axis.tlast   = last_beat & valid;
  assign backlog        = backlog_q;
  assign overflow_count = ovf_q;

endmodule

// File: tb/tb_axis_pattern_gen_mm.sv
// Scoreboard bench: stimulus pushes expected beats, a monitor pops and compares on handshakes.
module tb_axis_pattern_gen_mm;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, en_a, rdy_a;
  logic [1:0] mode_a;
  logic [4:0] bl_a;
  logic [31:0] ovf_a;
  logic       rst_b, en_b, rdy_b;
  logic [1:0] mode_b;
  logic [2:0] bl_b;
  logic [31:0] ovf_b;

  axis_pattern_gen_mm_if #(.TDATA_WIDTH(32)) ifa ();
  axis_pattern_gen_mm_if #(.TDATA_WIDTH(8))  ifb ();
  assign ifa.tready = rdy_a;
  assign ifb.tready = rdy_b;

  axis_pattern_gen_mm u_dut_a (
    .m_axis_aclk    (clk),
    .m_axis_areset  (rst_a),
    .enable         (en_a),
    .mode           (mode_a),
    .m_axis         (ifa),
    .backlog        (bl_a),
    .overflow_count (ovf_a)
  );

  axis_pattern_gen_mm #(
    .TDATA_WIDTH   (8),
    .COUNTER_START (10),
    .COUNTER_END   (20),
    .COUNTER_INCR  (3),
    .DIVIDER       (2),
    .FRAME_LEN     (4),
    .BACKLOG_DEPTH (4)
  ) u_dut_b (
    .m_axis_aclk    (clk),
    .m_axis_areset  (rst_b),
    .enable         (en_b),
    .mode           (mode_b),
    .m_axis         (ifb),
    .backlog        (bl_b),
    .overflow_count (ovf_b)
  );

  beat_t qa[$];
  beat_t qb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gap_exp = 0;
  int gap_left = 0;
  logic gap_skip = 1'b0;
  int last_hs_a = 0;

  logic [63:0] cnt_b_exp [9]  = '{64'd10, 64'd13, 64'd16, 64'd19, 64'd11, 64'd14, 64'd17,
                                  64'd20, 64'd12};
  logic [63:0] walk_b_exp [12] = '{64'd15, 64'd18, 64'd10, 64'h01, 64'h02, 64'h04, 64'h08,
                                   64'h10, 64'h20, 64'h40, 64'h80, 64'h01};
  logic        walk_b_last [12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                    1'b0, 1'b1, 1'b0};
  logic [63:0] lfsr_exp [7] = '{64'h1, 64'h3, 64'h6, 64'hd, 64'h1b, 64'h36, 64'h6d};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_a(input logic [63:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    qa.push_back(b);
  endtask

  task automatic push_b(input logic [63:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    qb.push_back(b);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input bit which, input int budget, input string name);
    int n = 0;
    while (((which == 1'b0) ? qa.size() : qb.size()) != 0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (((which == 1'b0) ? qa.size() : qb.size()) != 0) begin
      errors++;
      $display("FAIL %s: timeout with %0d beats outstanding, required 0", name,
               (which == 1'b0) ? qa.size() : qb.size());
      if (which == 1'b0) qa.delete();
      else qb.delete();
    end
  endtask

  task automatic run_monitor();
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst_a && ifa.tvalid && ifa.tready) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected_beat: got tdata %0h, required no beat", ifa.tdata);
        end else begin
          e = qa.pop_front();
          chk("a_tdata", 64'(ifa.tdata), e.data);
          chk("a_tlast", 64'(ifa.tlast), 64'(e.last));
        end
        if (gap_left > 0) begin
          if (gap_skip) gap_skip = 1'b0;
          else begin
            chk("a_beat_gap", 64'(cyc - last_hs_a), 64'(gap_exp));
            gap_left--;
          end
        end
        last_hs_a = cyc;
      end
      if (!rst_b && ifb.tvalid && ifb.tready) begin
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected_beat: got tdata %0h, required no beat", ifb.tdata);
        end else begin
          e = qb.pop_front();
          chk("b_tdata", 64'(ifb.tdata), e.data);
          chk("b_tlast", 64'(ifb.tlast), 64'(e.last));
        end
      end
    end
  endtask

  initial begin
    int n;
    rst_a = 1'b1; en_a = 1'b0; rdy_a = 1'b0; mode_a = 2'd0;
    rst_b = 1'b1; en_b = 1'b0; rdy_b = 1'b0; mode_b = 2'd0;
    fork
      run_monitor();
    join_none
    repeat (3) step();

    chk("a_rst_tvalid", 64'(ifa.tvalid), 64'd0);
    chk("a_rst_tlast", 64'(ifa.tlast), 64'd0);
    chk("a_rst_tdata", 64'(ifa.tdata), 64'd0);
    chk("a_rst_backlog", 64'(bl_a), 64'd0);
    chk("a_rst_overflow", 64'(ovf_a), 64'd0);

    // Small DUT: wrapping counter 10..20 step 3, then walking-one requested mid-frame.
    for (int i = 0; i < 9; i++) push_b(cnt_b_exp[i], (i % 4) == 3);
    en_b = 1'b1; rdy_b = 1'b1; rst_b = 1'b0;
    wait_drain(1'b1, 200, "b_counter_drain");
    rdy_b = 1'b0;
    mode_b = 2'd2;
    for (int i = 0; i < 12; i++) push_b(walk_b_exp[i], walk_b_last[i]);
    rdy_b = 1'b1;
    wait_drain(1'b1, 200, "b_walk_drain");
    rdy_b = 1'b0; en_b = 1'b0;
    chk("b_overflow", 64'(ovf_b), 64'd0);

    // Default DUT: full counter lap plus wrap, tick spacing and first-tick latency.
    for (int k = 0; k < 257; k++) push_a(64'(k % 256), (k % 64) == 63);
    en_a = 1'b1; rdy_a = 1'b1;
    gap_exp = 8; gap_left = 20; gap_skip = 1'b1;
    rst_a = 1'b0;
    repeat (7) step();
    chk("a_valid_before_first_tick", 64'(ifa.tvalid), 64'd0);
    step();
    chk("a_valid_at_first_tick", 64'(ifa.tvalid), 64'd1);
    wait_drain(1'b0, 257 * 8 + 50, "a_counter_drain");
    rdy_a = 1'b0;
    chk("a_overflow_after_lap", 64'(ovf_a), 64'd0);

    // Backpressure: 200 clocks stalled holds 25 ticks, 16 kept and 9 dropped.
    repeat (128) step();
    chk("a_backlog_full_128", 64'(bl_a), 64'd16);
    chk("a_overflow_at_128", 64'(ovf_a), 64'd0);
    repeat (72) step();
    chk("a_backlog_full_200", 64'(bl_a), 64'd16);
    chk("a_overflow_at_200", 64'(ovf_a), 64'd9);
    for (int k = 1; k <= 20; k++) push_a(64'(k), 1'b0);
    gap_exp = 1; gap_left = 15; gap_skip = 1'b1;
    rdy_a = 1'b1;
    wait_drain(1'b0, 400, "a_backlog_drain");
    rdy_a = 1'b0;
    chk("a_overflow_held", 64'(ovf_a), 64'd9);

    // Mode change requested mid-frame: counter finishes the frame, then PRBS from the seed.
    mode_a = 2'd1;
    for (int k = 21; k <= 63; k++) push_a(64'(k), k == 63);
    for (int i = 0; i < 7; i++) push_a(lfsr_exp[i], 1'b0);
    rdy_a = 1'b1;
    wait_drain(1'b0, 60 * 8 + 50, "a_mode_switch_drain");
    rdy_a = 1'b0;

    // Asynchronous reset with five samples pending.
    n = 0;
    while (bl_a != 5'd5 && n < 100) begin
      step();
      n++;
    end
    chk("a_backlog_reaches_5", 64'(bl_a), 64'd5);
    chk("a_overflow_before_reset", 64'(ovf_a), 64'd9);
    #2 rst_a = 1'b1;
    #1;
    chk("a_async_rst_tvalid", 64'(ifa.tvalid), 64'd0);
    chk("a_async_rst_tlast", 64'(ifa.tlast), 64'd0);
    chk("a_async_rst_tdata", 64'(ifa.tdata), 64'd0);
    chk("a_async_rst_backlog", 64'(bl_a), 64'd0);
    chk("a_async_rst_overflow", 64'(ovf_a), 64'd0);
    mode_a = 2'd0;
    for (int k = 0; k < 3; k++) push_a(64'(k), 1'b0);
    repeat (3) step();
    rdy_a = 1'b1;
    rst_a = 1'b0;
    repeat (7) step();
    chk("a_restart_valid_before_tick", 64'(ifa.tvalid), 64'd0);
    step();
    chk("a_restart_valid_at_tick", 64'(ifa.tvalid), 64'd1);
    wait_drain(1'b0, 100, "a_restart_drain");
    rdy_a = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
